// File: rtl/counter4_extend_pkg.sv
// -----------------------------------------------------------------------------
// counter4_extend_pkg
//   Shared widths, limits and the per-sample event type for counter4_extend.
//   HI_W      : width of the extension (upper) part of the extended count
//   LO_W      : width of the upstream counter4 value (lower part)
//   ERR_CNT_W : width of the saturating illegal-jump counter
// -----------------------------------------------------------------------------
package counter4_extend_pkg;

  localparam int HI_W      = 8;
  localparam int LO_W      = 4;
  localparam int ERR_CNT_W = 4;
  localparam int EXT_W     = HI_W + LO_W;

  localparam logic [LO_W-1:0]      LO_MAX      = '1;
  localparam logic [HI_W-1:0]      HI_MAX      = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // How the current upstream sample relates to the previous one.
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    STEP = 3'd1,
    WRAP = 3'd2,
    CLR  = 3'd3,
    JUMP = 3'd4
  } count_event_e;

  // Increment that sticks at the all-ones value instead of rolling over.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : ERR_CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/count4_delta_classify.sv
// -----------------------------------------------------------------------------
// count4_delta_classify
//   Purely combinational classifier of one upstream counter4 sample against
//   the previous one. First matching rule wins: HOLD, WRAP, STEP, CLR, JUMP.
//   Ports:
//     prev_i       : previously registered upstream value
//     cur_i        : current upstream value
//     prev_valid_i : prev_i holds a real sample (0 right after reset)
//     ev_o         : event classification
//   With prev_valid_i=0 there is nothing to compare against, so HOLD is
//   reported; the parent treats that sample as a plain load.
// -----------------------------------------------------------------------------
module count4_delta_classify
  import counter4_extend_pkg::*;
(
  input  logic [LO_W-1:0] prev_i,
  input  logic [LO_W-1:0] cur_i,
  input  logic            prev_valid_i,
  output count_event_e    ev_o
);

  logic [LO_W-1:0] prev_plus1;
  assign prev_plus1 = LO_W'(prev_i + 1'b1);

  always_comb begin
    ev_o = HOLD;
    if (!prev_valid_i) begin
      ev_o = HOLD;
    end else if (cur_i == prev_i) begin
      ev_o = HOLD;
    end else if ((prev_i == LO_MAX) && (cur_i == '0)) begin
      ev_o = WRAP;
    end else if (cur_i == prev_plus1) begin
      ev_o = STEP;
    end else if (cur_i == '0) begin
      // Any non-wrap return to zero means the upstream counter was reset.
      ev_o = CLR;
    end else begin
      ev_o = JUMP;
    end
  end

endmodule

// File: rtl/counter4_extend.sv
// -----------------------------------------------------------------------------
// counter4_extend
//   Extends a free-running 4-bit upstream counter to 12 bits by counting its
//   15->0 wraps, and flags upstream resets and illegal jumps.
//   Ports:
//     GCLK_Pad                 : system clock, rising edge
//     rstn_Pad                 : synchronous active-low reset
//     count0_Pad..count3_Pad   : upstream count bits (count0 = LSB)
//     clr_Pad                  : synchronous clear of ovf/err/err_cnt
//     ext_count_Pad[11:0]      : {hi[7:0], lo[3:0]}
//     chg_Pad                  : pulse, ext_count changed
//     wrap_Pad                 : pulse, upstream wrapped 15->0
//     rst_seen_Pad             : pulse, upstream reset detected
//     ovf_Pad                  : sticky, hi rolled over 255->0
//     err_Pad                  : sticky, illegal jump seen
//     err_cnt_Pad[3:0]         : saturating illegal-jump count
//   Every output comes straight from a flop: results for the sample taken at
//   edge N are visible after edge N.
// -----------------------------------------------------------------------------
module counter4_extend
  import counter4_extend_pkg::*;
(
  input  logic                 GCLK_Pad,
  input  logic                 rstn_Pad,
  input  logic                 count0_Pad,
  input  logic                 count1_Pad,
  input  logic                 count2_Pad,
  input  logic                 count3_Pad,
  input  logic                 clr_Pad,
  output logic [EXT_W-1:0]     ext_count_Pad,
  output logic                 chg_Pad,
  output logic                 wrap_Pad,
  output logic                 rst_seen_Pad,
  output logic                 ovf_Pad,
  output logic                 err_Pad,
  output logic [ERR_CNT_W-1:0] err_cnt_Pad
);

  logic [LO_W-1:0] cur;
  assign cur = {count3_Pad, count2_Pad, count1_Pad, count0_Pad};

  // lo always equals the last accepted sample (HOLD keeps it, every other
  // event loads cur or zero, which equals cur), so lo_q doubles as "prev".
  logic [LO_W-1:0]      lo_q,         lo_d;
  logic [HI_W-1:0]      hi_q,         hi_d;
  logic                 prev_valid_q, prev_valid_d;
  logic                 chg_q,        chg_d;
  logic                 wrap_q,       wrap_d;
  logic                 rst_seen_q,   rst_seen_d;
  logic                 ovf_q,        ovf_d;
  logic                 err_q,        err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

  count_event_e ev;

  count4_delta_classify u_classify (
    .prev_i       (lo_q),
    .cur_i        (cur),
    .prev_valid_i (prev_valid_q),
    .ev_o         (ev)
  );

  always_comb begin
    lo_d         = lo_q;
    hi_d         = hi_q;
    prev_valid_d = 1'b1;
    chg_d        = 1'b0;
    wrap_d       = 1'b0;
    rst_seen_d   = 1'b0;
    // clr is applied first so a coincident event below can override it.
    ovf_d        = clr_Pad ? 1'b0 : ovf_q;
    err_d        = clr_Pad ? 1'b0 : err_q;
    err_cnt_d    = clr_Pad ? '0   : err_cnt_q;

    if (!prev_valid_q) begin
      // First sample after reset: adopt it without judging it.
      lo_d  = cur;
      chg_d = (cur != '0);
    end else begin
      case (ev)
        HOLD: begin
        end
        STEP: begin
          lo_d  = cur;
          chg_d = 1'b1;
        end
        WRAP: begin
          lo_d   = '0;
          hi_d   = HI_W'(hi_q + 1'b1);
          wrap_d = 1'b1;
          chg_d  = 1'b1;
          if (hi_q == HI_MAX) begin
            ovf_d = 1'b1;
          end
        end
        CLR: begin
          lo_d       = '0;
          hi_d       = '0;
          rst_seen_d = 1'b1;
          chg_d      = ({hi_q, lo_q} != '0);
        end
        JUMP: begin
          lo_d      = cur;
          err_d     = 1'b1;
          // err_cnt_d is already zero here when clr_Pad is set, giving 1.
          err_cnt_d = sat_inc(err_cnt_d);
          chg_d     = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge GCLK_Pad) begin
    if (!rstn_Pad) begin
      lo_q         <= '0;
      hi_q         <= '0;
      prev_valid_q <= 1'b0;
      chg_q        <= 1'b0;
      wrap_q       <= 1'b0;
      rst_seen_q   <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      prev_valid_q <= prev_valid_d;
      chg_q        <= chg_d;
      wrap_q       <= wrap_d;
      rst_seen_q   <= rst_seen_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign ext_count_Pad = {hi_q, lo_q};
  assign chg_Pad       = chg_q;
  assign wrap_Pad      = wrap_q;
  assign rst_seen_Pad  = rst_seen_q;
  assign ovf_Pad       = ovf_q;
  assign err_Pad       = err_q;
  assign err_cnt_Pad   = err_cnt_q;

endmodule

// File: tb/tb_counter4_extend.sv
// -----------------------------------------------------------------------------
// tb_counter4_extend
//   Directed stimulus for counter4_extend. Each driven cycle pushes the
//   hand-derived expected output vector into exp_q; a monitor on the falling
//   edge pops one entry per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter4_extend;
  import counter4_extend_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        clr  = 1'b0;
  logic        c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
  logic [11:0] ext;
  logic        chg, wrap, rs, ovf, err;
  logic [3:0]  ecnt;

  counter4_extend dut (
    .GCLK_Pad      (clk),
    .rstn_Pad      (rstn),
    .count0_Pad    (c0),
    .count1_Pad    (c1),
    .count2_Pad    (c2),
    .count3_Pad    (c3),
    .clr_Pad       (clr),
    .ext_count_Pad (ext),
    .chg_Pad       (chg),
    .wrap_Pad      (wrap),
    .rst_seen_Pad  (rs),
    .ovf_Pad       (ovf),
    .err_Pad       (err),
    .err_cnt_Pad   (ecnt)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk;
    logic [7:0]  tag;
    logic [20:0] v;   // {ext, chg, wrap, rs, ovf, err, ecnt}
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Expected sticky state and count, maintained by the scenarios.
  logic       e_ovf  = 1'b0;
  logic       e_err  = 1'b0;
  logic [3:0] e_ecnt = 4'd0;
  logic [7:0] e_hi   = 8'd0;
  logic [3:0] e_lo   = 4'd0;
  logic [7:0] scen   = 8'd0;

  logic [20:0] got;
  assign got = {ext, chg, wrap, rs, ovf, err, ecnt};

  always @(negedge clk) begin : monitor
    sb_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL out_vec scen=%0d got ext=%h chg=%b wrap=%b rs=%b ovf=%b err=%b ecnt=%0d | exp ext=%h chg=%b wrap=%b rs=%b ovf=%b err=%b ecnt=%0d",
                   e.tag, got[20:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
                   e.v[20:9], e.v[8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one sample; expectation is for the outputs after the next rising edge.
  task automatic step(input logic [3:0] cnt, input logic c, input logic rn,
                      input logic chk, input logic [11:0] x,
                      input logic ch, input logic w, input logic r);
    @(negedge clk);
    {c3, c2, c1, c0} = cnt;
    clr  = c;
    rstn = rn;
    @(posedge clk);
    exp_q.push_back({chk, scen, x, ch, w, r, e_ovf, e_err, e_ecnt});
  endtask

  // Count up from e_lo to 15, then wrap to 0 (optionally with clr at the wrap).
  task automatic up_to_wrap(input logic c);
    for (int i = int'(e_lo) + 1; i <= 15; i++)
      step(4'(i), 1'b0, 1'b1, 1'b1, {e_hi, 4'(i)}, 1'b1, 1'b0, 1'b0);
    if (c) begin
      e_ovf  = 1'b0;
      e_err  = 1'b0;
      e_ecnt = 4'd0;
    end
    if (e_hi == 8'hFF) e_ovf = 1'b1;
    e_hi = e_hi + 8'd1;
    e_lo = 4'd0;
    step(4'd0, c, 1'b1, 1'b1, {e_hi, 4'h0}, 1'b1, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    scen = 8'd1;
    step(4'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);

    // Count 0..15,0,1: first sample is a silent load of 0
    scen = 8'd2;
    step(4'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++)
      step(4'(i), 1'b0, 1'b1, 1'b1, 12'(i), 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b1, 1'b1, 1'b0);
    step(4'd1, 1'b0, 1'b1, 1'b1, 12'h011, 1'b1, 1'b0, 1'b0);

    // Reach 0x023, then upstream reset 3->0
    scen = 8'd3;
    for (int i = 2; i <= 15; i++)
      step(4'(i), 1'b0, 1'b1, 1'b1, 12'h010 + 12'(i), 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++)
      step(4'(i), 1'b0, 1'b1, 1'b1, 12'h020 + 12'(i), 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1);

    // Step to 5 and hold for 20 cycles
    scen = 8'd4;
    for (int i = 1; i <= 5; i++)
      step(4'(i), 1'b0, 1'b1, 1'b1, 12'(i), 1'b1, 1'b0, 1'b0);
    repeat (20) step(4'd5, 1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 1'b0, 1'b0);

    // Illegal jumps: 5->0 (upstream reset), 1, 2, then 2->7 and 17 more jumps
    scen = 8'd5;
    step(4'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1);
    step(4'd1, 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
    e_err = 1'b1; e_ecnt = 4'd1;
    step(4'd7, 1'b0, 1'b1, 1'b1, 12'h007, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 18; k++) begin
      e_ecnt = (k > 15) ? 4'd15 : 4'(k);
      step((k % 2 == 0) ? 4'd2 : 4'd7, 1'b0, 1'b1, 1'b1,
           (k % 2 == 0) ? 12'h002 : 12'h007, 1'b1, 1'b0, 1'b0);
    end
    // clr together with a jump: the jump wins
    e_err = 1'b1; e_ecnt = 4'd1;
    step(4'd7, 1'b1, 1'b1, 1'b1, 12'h007, 1'b1, 1'b0, 1'b0);
    // clr alone on a hold
    e_err = 1'b0; e_ecnt = 4'd0;
    step(4'd7, 1'b1, 1'b1, 1'b1, 12'h007, 1'b0, 1'b0, 1'b0);

    // Reach 0x047 (via a jump so err is set), then reset with clr also high
    scen = 8'd6;
    e_hi = 8'd0; e_lo = 4'd7;
    repeat (4) up_to_wrap(1'b0);
    e_err = 1'b1; e_ecnt = 4'd1;
    step(4'd7, 1'b0, 1'b1, 1'b1, 12'h047, 1'b1, 1'b0, 1'b0);
    e_err = 1'b0; e_ecnt = 4'd0; e_ovf = 1'b0;
    step(4'd8, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    step(4'd9, 1'b0, 1'b1, 1'b1, 12'h009, 1'b1, 1'b0, 1'b0);
    e_hi = 8'd0; e_lo = 4'd9;

    // 255 wraps to hi=255, then one more -> ovf sticky until clr
    scen = 8'd7;
    repeat (255) up_to_wrap(1'b0);
    up_to_wrap(1'b0);
    step(4'd1, 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
    e_ovf = 1'b0;
    step(4'd2, 1'b1, 1'b1, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0);
    e_lo = 4'd2;

    // Overflow wrap coinciding with clr: ovf still set
    scen = 8'd8;
    repeat (255) up_to_wrap(1'b0);
    up_to_wrap(1'b1);
    step(4'd1, 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0);

    // Drain: the monitor must have consumed every entry
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries, exp 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter4_extend.md
COUNTER4_EXTEND -- requirements
Module: counter4_extend

Interface
REQ-001 SHALL have ports: GCLK_Pad  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have: rstn_Pad  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: count0_Pad..count3_Pad  input  1 each  4-bit count from upstream counter4 stage; count0 is LSB.
REQ-004 SHALL have: clr_Pad  input  1  synchronous clear of sticky flags and error count.
REQ-005 SHALL have: ext_count_Pad  output  12  extended count {hi[7:0], lo[3:0]}.
REQ-006 SHALL have: chg_Pad  output  1  one-cycle pulse when ext_count_Pad changes.
REQ-007 SHALL have: wrap_Pad  output  1  one-cycle pulse on a 15->0 wrap.
REQ-008 SHALL have: rst_seen_Pad  output  1  one-cycle pulse on a detected upstream reset.
REQ-009 SHALL have: ovf_Pad  output  1  sticky; hi wrapped 255->0.
REQ-010 SHALL have: err_Pad  output  1  sticky; illegal jump seen.
REQ-011 SHALL have: err_cnt_Pad  output  4  illegal-jump count, saturating at 15.

Function
REQ-012 SHALL sample cur = {count3..count0} every GCLK_Pad edge and compare it against registered prev.
REQ-013 SHALL treat the first sample after reset (prev_valid=0) as a plain load: lo<=cur, prev_valid<=1, no pulses, chg_Pad=1 only if cur!=0.
REQ-014 SHALL classify each later sample, first match wins: HOLD cur==prev; WRAP prev==15 and cur==0; STEP cur==prev+1; CLR cur==0 and prev!=0; JUMP otherwise.
REQ-015 HOLD SHALL change nothing; all pulses 0.
REQ-016 STEP SHALL set lo<=cur, chg_Pad=1.
REQ-017 WRAP SHALL set lo<=0, hi<=hi+1 mod 256, wrap_Pad=1, chg_Pad=1; if hi was 255, ovf_Pad<=1.
REQ-018 CLR SHALL set lo<=0, hi<=0, rst_seen_Pad=1, chg_Pad=1 if ext_count was non-zero; ovf_Pad unaffected.
REQ-019 JUMP SHALL set lo<=cur, hi unchanged, err_Pad<=1, err_cnt_Pad<=min(err_cnt+1,15), chg_Pad=1.
REQ-020 All outputs SHALL be registered; latency from count sample edge N to ext_count_Pad/pulses valid is one cycle (after edge N).
REQ-021 Pulses SHALL be high exactly one cycle per event; back-to-back events produce back-to-back pulses.
REQ-022 clr_Pad=1 SHALL clear ovf_Pad, err_Pad and err_cnt_Pad to 0 without affecting hi/lo.
REQ-023 If clr_Pad and JUMP coincide, the event SHALL win: err_Pad=1, err_cnt_Pad=1.
REQ-024 If clr_Pad and a WRAP from hi=255 coincide, ovf_Pad SHALL be 1.

Reset
REQ-025 rstn_Pad=0 at an edge SHALL set ext_count_Pad=0, all pulses 0, ovf_Pad=0, err_Pad=0, err_cnt_Pad=0, prev_valid=0.
REQ-026 Reset SHALL override clr_Pad and any in-progress classification; first sample after release follows REQ-013.

Structure
REQ-027 Shared package counter4_extend_pkg SHALL hold HI_W=8, LO_W=4, ERR_CNT_W=4 and the event enum {HOLD, STEP, WRAP, CLR, JUMP}.
REQ-028 Classification SHALL be a combinational sub-module count4_delta_classify (inputs prev, cur, prev_valid; output event enum).

Verification
REQ-029 Reset, then count 0..15,0,1 one step per cycle -> ext_count 0x000..0x00F,0x010,0x011; one wrap_Pad pulse; err_Pad=0.
REQ-030 Preload hi=255 via 255 wraps, then 15->0 -> ext_count=0x000, wrap_Pad=1, ovf_Pad=1 sticky until clr_Pad.
REQ-031 At ext_count=0x023, input 3->0 -> ext_count=0x000, rst_seen_Pad=1, wrap_Pad=0.
REQ-032 Input 2->7, then 17 further illegal jumps -> err_Pad=1, err_cnt_Pad saturates at 15; clr_Pad coinciding with a jump -> err_cnt_Pad=1.
REQ-033 Input held at 5 for 20 cycles -> chg_Pad=0 throughout, ext_count constant.
REQ-034 rstn_Pad low mid-count at ext_count=0x047 -> all outputs 0 next cycle; first post-reset sample 9 -> ext_count=0x009, no pulses except chg_Pad.
